// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer (DIV/MOD/DIVU/MODU) for the EX stage.
// Optional DIV_EARLY_OUT_EN: skip iteration when |src1| < |src2| and src2 != 0.
module div_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_dest,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_dest
);

  localparam int CW = $clog2(XLEN);

  // Divide opcode encodings shared with the 3R instruction decoder
  localparam logic [7:0] OP_DIV  = 8'h30;
  localparam logic [7:0] OP_DIVU = 8'h31;
  localparam logic [7:0] OP_MOD  = 8'h32;
  localparam logic [7:0] OP_MODU = 8'h33;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvs_q, src1_q;
  logic [CW-1:0]    cnt_q;
  logic             want_rem_q, quo_neg_q, rem_neg_q, div0_q;
  logic [TAG_W-1:0] dest_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_result_q;
  logic [TAG_W-1:0] out_dest_q;

  logic             op_ok, is_signed_d, want_rem_d, s1neg_d, s2neg_d, accept, early;
  logic [XLEN-1:0]  mag1_d, mag2_d, early_res_d;
  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    sub;
  logic             borrow;
  logic [XLEN-1:0]  rem_nx, quo_nx, res_fix;

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_dest   = out_dest_q;

  always_comb begin
    op_ok       = (in_op == OP_DIV) || (in_op == OP_DIVU) ||
                  (in_op == OP_MOD) || (in_op == OP_MODU);
    is_signed_d = (in_op == OP_DIV) || (in_op == OP_MOD);
    want_rem_d  = (in_op == OP_MOD) || (in_op == OP_MODU);
    s1neg_d     = is_signed_d & in_src1[XLEN-1];
    s2neg_d     = is_signed_d & in_src2[XLEN-1];
    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude
    mag1_d      = s1neg_d ? -in_src1 : in_src1;
    mag2_d      = s2neg_d ? -in_src2 : in_src2;
    accept      = in_valid & in_ready & ~flush & op_ok;
    early_res_d = want_rem_d ? in_src1 : '0;
  end

`ifdef DIV_EARLY_OUT_EN
  assign early = (mag1_d < mag2_d) && (in_src2 != '0);
`else
  assign early = 1'b0;
`endif

  // One restoring step. A set shifted-out MSB means the partial remainder already exceeds
  // the divisor, so the XLEN+1-bit subtract only decides the low-word case.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    sub    = {1'b0, rem_sh[XLEN-1:0]} - {1'b0, dvs_q};
    borrow = sub[XLEN] & ~rem_sh[XLEN];
    rem_nx = borrow ? rem_sh[XLEN-1:0] : sub[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], ~borrow};
    if (div0_q)
      res_fix = want_rem_q ? src1_q : '1;
    else if (want_rem_q)
      res_fix = rem_neg_q ? -rem_nx : rem_nx;
    else
      res_fix = quo_neg_q ? -quo_nx : quo_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      src1_q       <= '0;
      cnt_q        <= '0;
      want_rem_q   <= 1'b0;
      quo_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
      div0_q       <= 1'b0;
      dest_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_dest_q   <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          rem_q      <= '0;
          quo_q      <= mag1_d;
          dvs_q      <= mag2_d;
          src1_q     <= in_src1;
          cnt_q      <= CW'(XLEN - 1);
          want_rem_q <= want_rem_d;
          quo_neg_q  <= s1neg_d ^ s2neg_d;
          rem_neg_q  <= s1neg_d;
          div0_q     <= (in_src2 == '0);
          dest_q     <= in_dest;
          if (early) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= early_res_d;
            out_dest_q   <= in_dest;
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= res_fix;
            out_dest_q   <= dest_q;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus random ops against an arithmetic model.
module tb_div_ctrl;

  localparam logic [7:0] OP_DIV  = 8'h30;
  localparam logic [7:0] OP_DIVU = 8'h31;
  localparam logic [7:0] OP_MOD  = 8'h32;
  localparam logic [7:0] OP_MODU = 8'h33;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic        in_ready, busy, out_valid;
  logic [7:0]  in_op;
  logic [31:0] in_src1, in_src2, out_result;
  logic [4:0]  in_dest, out_dest;

  int n_asserts = 0;
  int n_fail    = 0;

  div_ctrl #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
    .flush(flush), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn, rem;
    int sa, sb;
    sgn = (op == OP_DIV) || (op == OP_MOD);
    rem = (op == OP_MOD) || (op == OP_MODU);
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (!sgn) return rem ? a % b : a / b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    sa = a;
    sb = b;
    return rem ? sa % sb : sa / sb;
  endfunction

  function automatic int ref_lat(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    bit sgn;
    sgn = (op == OP_DIV) || (op == OP_MOD);
    ma = (sgn && a[31]) ? 64'h1_0000_0000 - a : a;
    mb = (sgn && b[31]) ? 64'h1_0000_0000 - b : b;
`ifdef DIV_EARLY_OUT_EN
    if (b != 0 && ma < mb) return 1;
`else
    if (ma < 0 || mb < 0) return 0;
`endif
    return 33;
  endfunction

  // Caller sits at a negedge. With peek set, a new valid op is driven alongside the
  // out_ready handshake and must not be accepted in that cycle.
  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input int hold, input bit peek);
    logic [31:0] exp;
    int lat, n;
    exp = ref_res(op, a, b);
    lat = ref_lat(op, a, b);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1; in_op = op; in_src1 = a; in_src2 = b; in_dest = d;
    @(negedge clk);
    in_valid = 0; in_op = 8'h00; in_src1 = $urandom; in_src2 = $urandom; in_dest = 5'($urandom);
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    check("result", out_result, exp);
    check("dest", {27'b0, out_dest}, {27'b0, d});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, exp);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    if (peek) begin
      in_valid = 1; in_op = OP_DIVU; in_src1 = 32'd9; in_src2 = 32'd4;
    end
    @(negedge clk);
    out_ready = 0;
    check("in_ready_after_wb", in_ready, 1);
    check("valid_after_wb", out_valid, 0);
    if (peek) check("no_accept_in_handshake", busy, 0);
  endtask

  task automatic abort_mid_calc(input bit use_reset);
    bit seen;
    in_valid = 1; in_op = OP_DIV; in_src1 = 32'd100; in_src2 = 32'd7; in_dest = 5'd3;
    @(negedge clk);
    in_valid = 0;
    repeat (14) @(negedge clk);
    if (use_reset) reset = 1; else flush = 1;
    @(negedge clk);
    reset = 0; flush = 0;
    check(use_reset ? "reset_busy" : "flush_busy", busy, 0);
    check(use_reset ? "reset_in_ready" : "flush_in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check(use_reset ? "reset_no_stale" : "flush_no_stale", seen, 0);
  endtask

  logic [7:0] ops [4] = '{OP_DIV, OP_DIVU, OP_MOD, OP_MODU};

  initial begin
    logic [31:0] ra, rb;
    reset = 1; in_valid = 0; flush = 0; out_ready = 0;
    in_op = 0; in_src1 = 0; in_src2 = 0; in_dest = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_dest", {27'b0, out_dest}, 0);

    do_op(OP_DIV,  32'd100,      32'd7,        5'd11, 0, 0);
    do_op(OP_MOD,  32'd100,      32'd7,        5'd12, 0, 0);
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,       5'd1,  0, 0);
    do_op(OP_MOD,  32'hFFFF_FFF9, 32'd2,       5'd2,  0, 0);
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd2,       5'd3,  0, 0);
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0, 0);
    do_op(OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0, 0);
    do_op(OP_DIVU, 32'd5,        32'd0,        5'd6,  0, 0);
    do_op(OP_MODU, 32'd5,        32'd0,        5'd7,  0, 0);
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd0,       5'd8,  0, 0);
    do_op(OP_MOD,  32'hFFFF_FFF9, 32'd0,       5'd9,  0, 0);
    do_op(OP_DIVU, 32'd3,        32'd9,        5'd10, 0, 0);
    do_op(OP_MODU, 32'd3,        32'd9,        5'd13, 0, 0);

    do_op(OP_DIV,  32'd100,      32'd7,        5'd21, 10, 1);
    do_op(OP_DIVU, 32'd9,        32'd4,        5'd22, 0, 0);

    abort_mid_calc(0);
    abort_mid_calc(1);
    check("post_reset_result", out_result, 0);

    in_valid = 1; flush = 1; in_op = OP_DIVU; in_src1 = 32'd50; in_src2 = 32'd5;
    @(negedge clk);
    in_valid = 0; flush = 0;
    check("flush_blocks_accept", busy, 0);
    in_valid = 1; in_op = 8'h01;
    @(negedge clk);
    in_valid = 0;
    check("bad_op_ignored", busy, 0);

    repeat (40) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = $urandom_range(0, 9); end
        2: begin ra = $urandom_range(0, 20); rb = $urandom; end
        default: begin
          ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF - $urandom_range(0, 3);
          rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 2));
        end
      endcase
      do_op(ops[$urandom_range(0, 3)], ra, rb, 5'($urandom), $urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
